// File: rtl/pcs_pkg.sv
// Shared PCS definitions: 64b/66b sync header codes, scrambler taps/seed and
// the parallel self-synchronising descramble function.
package pcs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int SCR_TAP_A = 39;
    localparam int SCR_TAP_B = 58;
    localparam logic [SCR_TAP_B-1:0] SCR_SEED = '1;

    typedef enum logic {
        ST_PRIMING = 1'b0,
        ST_RUN     = 1'b1
    } prime_state_t;

    // {din, state} lines up so that bit k-58 of the received stream sits at
    // index k; tap x^58 is then at index i and tap x^39 at index i+19.
    function automatic logic [63:0] descramble64(input logic [SCR_TAP_B-1:0] state,
                                                 input logic [63:0]          din);
        logic [63+SCR_TAP_B:0] ext;
        logic [63:0]           res;
        ext = {din, state};
        res = '0;
        for (int i = 0; i < 64; i++) begin
            res[i] = din[i] ^ ext[i + SCR_TAP_B - SCR_TAP_A] ^ ext[i];
        end
        return res;
    endfunction

    function automatic logic header_ok(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/pcs_rx_descrambler_if.sv
// Block-level bus between block sync, the RX descrambler and the 64b/66b decoder.
interface pcs_rx_descrambler_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ERR_CNT_W  = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [1:0]            header_in;
    logic                  data_in_valid;
    logic                  resync;
    logic                  clr_cnt;

    logic [DATA_WIDTH-1:0] data_out;
    logic [1:0]            header_out;
    logic                  data_out_valid;
    logic                  primed;
    logic                  hdr_err;
    logic [ERR_CNT_W-1:0]  hdr_err_cnt;

    modport master (
        output data_in, header_in, data_in_valid, resync, clr_cnt,
        input  data_out, header_out, data_out_valid, primed, hdr_err, hdr_err_cnt
    );

    modport slave (
        input  data_in, header_in, data_in_valid, resync, clr_cnt,
        output data_out, header_out, data_out_valid, primed, hdr_err, hdr_err_cnt
    );
endinterface

// File: rtl/pcs_sat_counter.sv
// Saturating event counter with synchronous clear; a clear coinciding with an
// event restarts the count at one so that event is not lost.
module pcs_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= {{(WIDTH-1){1'b0}}, inc};
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pcs_rx_descrambler.sv
// RX 64b/66b payload descrambler, G(x) = 1 + x^39 + x^58, with sync-header
// check, priming state machine and saturating invalid-header counter.
module pcs_rx_descrambler
    import pcs_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ERR_CNT_W  = 8,
    parameter int PRIME_DROP = 0
) (
    input logic                  clk,
    input logic                  rst,
    pcs_rx_descrambler_if.slave  bus
);

    logic [SCR_TAP_B-1:0]  scr_state;
    prime_state_t          state;
    logic [DATA_WIDTH-1:0] descr;
    logic                  hdr_bad;
    logic                  drop_block;

    logic [DATA_WIDTH-1:0] data_out_r;
    logic [1:0]            header_out_r;
    logic                  valid_out_r;
    logic                  hdr_err_r;
    logic [ERR_CNT_W-1:0]  err_cnt;

    assign descr      = descramble64(scr_state, bus.data_in);
    assign hdr_bad    = bus.data_in_valid && !header_ok(bus.header_in);
    assign drop_block = (PRIME_DROP != 0) && (state == ST_PRIMING);

    // The line bits, not the descrambled bits, are fed back; resync only
    // restarts priming and never disturbs the shift state.
    always_ff @(posedge clk) begin
        if (rst) begin
            scr_state    <= SCR_SEED;
            state        <= ST_PRIMING;
            data_out_r   <= '0;
            header_out_r <= '0;
            valid_out_r  <= 1'b0;
            hdr_err_r    <= 1'b0;
        end else begin
            valid_out_r <= bus.data_in_valid && !drop_block;
            hdr_err_r   <= hdr_bad;
            if (bus.data_in_valid) begin
                scr_state    <= bus.data_in[DATA_WIDTH-1 -: SCR_TAP_B];
                data_out_r   <= descr;
                header_out_r <= bus.header_in;
            end
            if (bus.resync) begin
                state <= ST_PRIMING;
            end else if (bus.data_in_valid) begin
                state <= ST_RUN;
            end
        end
    end

    pcs_sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hdr_bad),
        .clr (bus.clr_cnt),
        .cnt (err_cnt)
    );

    assign bus.data_out       = data_out_r;
    assign bus.header_out     = header_out_r;
    assign bus.data_out_valid = valid_out_r;
    assign bus.primed         = (state == ST_RUN);
    assign bus.hdr_err        = hdr_err_r;
    assign bus.hdr_err_cnt    = err_cnt;

endmodule

// File: tb/tb_pcs_rx_descrambler.sv
// Scoreboard bench for pcs_rx_descrambler: two instances (no drop / 8-bit count and
// PRIME_DROP / 4-bit count) share one stimulus, checked against bit-serial models.
module tb_pcs_rx_descrambler;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pcs_rx_descrambler_if #(.DATA_WIDTH(64), .ERR_CNT_W(8)) bus0 ();
    pcs_rx_descrambler_if #(.DATA_WIDTH(64), .ERR_CNT_W(4)) bus1 ();

    pcs_rx_descrambler #(.DATA_WIDTH(64), .ERR_CNT_W(8), .PRIME_DROP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    pcs_rx_descrambler #(.DATA_WIDTH(64), .ERR_CNT_W(4), .PRIME_DROP(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  hdr;
        logic        err;
        int          cnt;
        logic [63:0] payload;
        bit          must_match;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    int total = 0;
    int bad   = 0;

    bit rx_line[$];
    bit tx_line[$];
    bit primed_m[2];
    int cnt_m[2];
    int cnt_max[2] = '{255, 15};
    bit drop_m[2]  = '{1'b0, 1'b1};
    bit tx_synced;
    int blk_since_rst;
    logic [63:0] last_dout0;
    logic [1:0]  last_hdr0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bit-serial line models: each bit looks 39 and 58 bits back along the wire.
    task automatic seedLine(output bit line[$]);
        line.delete();
        repeat (58) line.push_back(1'b1);
    endtask

    task automatic rxModel(input logic [63:0] d, output logic [63:0] o);
        for (int i = 0; i < 64; i++) begin
            o[i] = d[i] ^ rx_line[rx_line.size() - 39] ^ rx_line[rx_line.size() - 58];
            rx_line.push_back(d[i]);
            void'(rx_line.pop_front());
        end
    endtask

    task automatic txModel(input logic [63:0] p, output logic [63:0] s);
        for (int i = 0; i < 64; i++) begin
            s[i] = p[i] ^ tx_line[tx_line.size() - 39] ^ tx_line[tx_line.size() - 58];
            tx_line.push_back(s[i]);
            void'(tx_line.pop_front());
        end
    endtask

    task automatic applyStimulus(input logic [63:0] d, input logic [1:0] h, input bit v,
                                 input bit rs, input bit cc, input bit r,
                                 input logic [63:0] payload, input bit mm);
        logic [63:0] dout;
        bit          err;
        rst                = r;
        bus0.data_in       = d;  bus1.data_in       = d;
        bus0.header_in     = h;  bus1.header_in     = h;
        bus0.data_in_valid = v;  bus1.data_in_valid = v;
        bus0.resync        = rs; bus1.resync        = rs;
        bus0.clr_cnt       = cc; bus1.clr_cnt       = cc;
        dout = '0;
        if (r) begin
            seedLine(rx_line);
            primed_m      = '{1'b0, 1'b0};
            cnt_m         = '{0, 0};
            blk_since_rst = 0;
            last_dout0    = '0;
            last_hdr0     = '0;
        end else begin
            err = v && (h == 2'b00 || h == 2'b11);
            if (v) begin
                rxModel(d, dout);
                last_dout0 = dout;
                last_hdr0  = h;
            end
            for (int k = 0; k < 2; k++) begin
                if (cc)
                    cnt_m[k] = int'(err);
                else if (err && cnt_m[k] < cnt_max[k])
                    cnt_m[k]++;
                if (v && !(drop_m[k] && !primed_m[k])) begin
                    if (k == 0) q0.push_back('{dout, h, err, cnt_m[k], payload, mm});
                    else        q1.push_back('{dout, h, err, cnt_m[k], payload, mm});
                end
                if (rs)     primed_m[k] = 1'b0;
                else if (v) primed_m[k] = 1'b1;
            end
            if (v) blk_since_rst++;
        end
        @(posedge clk);
        #1;
        checkOutput("primed0", bus0.primed, primed_m[0]);
        checkOutput("primed1", bus1.primed, primed_m[1]);
        checkOutput("cnt0", bus0.hdr_err_cnt, cnt_m[0]);
        checkOutput("cnt1", bus1.hdr_err_cnt, cnt_m[1]);
    endtask

    task automatic sendBlock(input logic [63:0] payload, input logic [1:0] h, input bit cc);
        logic [63:0] scr;
        bit          mm;
        mm = tx_synced || (blk_since_rst >= 1);
        txModel(payload, scr);
        applyStimulus(scr, h, 1'b1, 1'b0, cc, 1'b0, payload, mm);
    endtask

    task automatic idle(input int n, input bit rs, input bit cc);
        for (int i = 0; i < n; i++)
            applyStimulus({$urandom, $urandom}, 2'($urandom), 1'b0, rs, cc, 1'b0, '0, 1'b0);
    endtask

    task automatic resetDut(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus({$urandom, $urandom}, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        seedLine(tx_line);
        tx_synced = 1'b1;
    endtask

    // Decoupled checker: pops one expectation per presented output block.
    always @(negedge clk) begin
        if (bus0.data_out_valid === 1'b1) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL dut0 spurious valid: got data %h expected no block", bus0.data_out);
            end else begin
                e0 = q0.pop_front();
                checkOutput("dut0 data", bus0.data_out, e0.data);
                checkOutput("dut0 header", bus0.header_out, e0.hdr);
                checkOutput("dut0 hdr_err", bus0.hdr_err, e0.err);
                checkOutput("dut0 cnt", bus0.hdr_err_cnt, e0.cnt);
                if (e0.must_match) checkOutput("dut0 loopback", bus0.data_out, e0.payload);
            end
        end else begin
            checkOutput("dut0 idle valid", bus0.data_out_valid, 1'b0);
            checkOutput("dut0 idle hdr_err", bus0.hdr_err, 1'b0);
        end
        if (bus1.data_out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL dut1 spurious valid: got data %h expected no block", bus1.data_out);
            end else begin
                e1 = q1.pop_front();
                checkOutput("dut1 data", bus1.data_out, e1.data);
                checkOutput("dut1 header", bus1.header_out, e1.hdr);
                checkOutput("dut1 hdr_err", bus1.hdr_err, e1.err);
                checkOutput("dut1 cnt", bus1.hdr_err_cnt, e1.cnt);
                if (e1.must_match) checkOutput("dut1 loopback", bus1.data_out, e1.payload);
            end
        end else begin
            checkOutput("dut1 idle valid", bus1.data_out_valid, 1'b0);
        end
    end

    initial begin
        rst = 1'b1;
        bus0.data_in = '0; bus0.header_in = '0; bus0.data_in_valid = 1'b0; bus0.resync = 1'b0; bus0.clr_cnt = 1'b0;
        bus1.data_in = '0; bus1.header_in = '0; bus1.data_in_valid = 1'b0; bus1.resync = 1'b0; bus1.clr_cnt = 1'b0;
        seedLine(rx_line);
        seedLine(tx_line);

        $display("[TB] reset state");
        resetDut(3);
        checkOutput("rst data_out", bus0.data_out, '0);
        checkOutput("rst header_out", bus0.header_out, '0);
        checkOutput("rst valid", bus0.data_out_valid, '0);
        checkOutput("rst hdr_err", bus0.hdr_err, '0);
        checkOutput("rst data_out dut1", bus1.data_out, '0);

        $display("[TB] all-zero first block against the seed");
        applyStimulus('0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 64'h03FF_FF80_0000_0000, 1'b1);
        tx_synced = 1'b0;

        $display("[TB] loopback with random gaps");
        resetDut(2);
        for (int n = 0; n < 1000; n++) begin
            sendBlock({$urandom, $urandom}, ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01, 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                idle($urandom_range(1, 3), 1'b0, 1'b0);
                checkOutput("gap hold data", bus0.data_out, last_dout0);
                checkOutput("gap hold header", bus0.header_out, last_hdr0);
            end
        end

        $display("[TB] header check");
        resetDut(2);
        sendBlock({$urandom, $urandom}, 2'b01, 1'b0);
        sendBlock({$urandom, $urandom}, 2'b10, 1'b0);
        sendBlock({$urandom, $urandom}, 2'b00, 1'b0);
        sendBlock({$urandom, $urandom}, 2'b11, 1'b0);
        sendBlock({$urandom, $urandom}, 2'b01, 1'b0);
        idle(1, 1'b0, 1'b0);

        $display("[TB] counter saturation and clear");
        resetDut(2);
        sendBlock({$urandom, $urandom}, 2'b01, 1'b0);
        for (int n = 0; n < 20; n++)
            sendBlock({$urandom, $urandom}, n[0] ? 2'b11 : 2'b00, 1'b0);
        sendBlock({$urandom, $urandom}, 2'b00, 1'b1);
        idle(1, 1'b0, 1'b1);
        idle(1, 1'b0, 1'b0);

        $display("[TB] seed mismatch: TX running during reset");
        tx_synced = 1'b0;
        for (int n = 0; n < 5; n++) begin
            logic [63:0] scr;
            txModel({$urandom, $urandom}, scr);
            applyStimulus(scr, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        end
        for (int n = 0; n < 10; n++)
            sendBlock({$urandom, $urandom}, 2'b10, 1'b0);

        $display("[TB] resync and mid-stream reset");
        idle(1, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b0);
        sendBlock({$urandom, $urandom}, 2'b01, 1'b0);
        sendBlock({$urandom, $urandom}, 2'b10, 1'b0);
        applyStimulus({$urandom, $urandom}, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        checkOutput("midrst data_out", bus0.data_out, '0);
        checkOutput("midrst header_out", bus0.header_out, '0);
        checkOutput("midrst valid", bus0.data_out_valid, '0);
        checkOutput("midrst hdr_err", bus0.hdr_err, '0);
        resetDut(1);
        for (int n = 0; n < 8; n++)
            sendBlock({$urandom, $urandom}, 2'b01, 1'b0);
        idle(3, 1'b0, 1'b0);

        checkOutput("dut0 queue drained", q0.size(), 0);
        checkOutput("dut1 queue drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
